// File: rtl/wl_sfifo_ctrl_if.sv
// Producer/consumer side of the single-clock FIFO controller: requests,
// thresholds, RAM addresses/enables and status flags.
interface wl_sfifo_ctrl_if #(parameter int L = 3);
  logic         we;
  logic         re;
  logic [L:0]   afull_th;
  logic [L:0]   aempty_th;
  logic         wr_ok;
  logic         rd_ok;
  logic [L-1:0] waddr;
  logic [L-1:0] raddr;
  logic [L:0]   count;
  logic         full;
  logic         empty;
  logic         afull;
  logic         aempty;
  logic         overflow;
  logic         underflow;
  logic         ovf_err;
  logic         udf_err;

  modport master (
    output we, re, afull_th, aempty_th,
    input  wr_ok, rd_ok, waddr, raddr, count, full, empty, afull, aempty,
           overflow, underflow, ovf_err, udf_err
  );

  modport slave (
    input  we, re, afull_th, aempty_th,
    output wr_ok, rd_ok, waddr, raddr, count, full, empty, afull, aempty,
           overflow, underflow, ovf_err, udf_err
  );
endinterface

// File: rtl/wl_sfifo_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM: wrap-at-depth
// pointers, occupancy count, registered level flags and error reporting.
module wl_sfifo_ctrl #(
  parameter int L = 3,
  parameter int H = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  wl_sfifo_ctrl_if.slave  bus
);
  localparam logic [L:0]   DEPTH = (L+1)'(H);
  localparam logic [L-1:0] LAST  = L'(H - 1);

  logic [L-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [L:0]   count_q, count_d;
  logic         full_q, full_d, empty_q, empty_d;
  logic         afull_q, afull_d, aempty_q, aempty_d;
  logic         ovf_q, ovf_d, udf_q, udf_d;
  logic         ovf_err_q, ovf_err_d, udf_err_q, udf_err_d;
  logic         wr_ok, rd_ok;

  // Acceptance looks only at registered flags, so a read never frees a slot
  // for a write in the same cycle.
  always_comb begin
    wr_ok = bus.we & ~full_q  & ~clr;
    rd_ok = bus.re & ~empty_q & ~clr;
  end

  always_comb begin
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    count_d   = count_q;
    full_d    = full_q;
    empty_d   = empty_q;
    afull_d   = afull_q;
    aempty_d  = aempty_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    ovf_err_d = ovf_err_q;
    udf_err_d = udf_err_q;
    if (clr) begin
      waddr_d   = '0;
      raddr_d   = '0;
      count_d   = '0;
      full_d    = 1'b0;
      empty_d   = 1'b1;
      afull_d   = 1'b0;
      aempty_d  = 1'b1;
      ovf_err_d = 1'b0;
      udf_err_d = 1'b0;
    end else begin
      if (wr_ok) waddr_d = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;
      if (rd_ok) raddr_d = (raddr_q == LAST) ? '0 : raddr_q + 1'b1;
      count_d   = count_q + (L+1)'(wr_ok) - (L+1)'(rd_ok);
      full_d    = (count_d == DEPTH);
      empty_d   = (count_d == '0);
      afull_d   = (count_d >= bus.afull_th);
      aempty_d  = (count_d <= bus.aempty_th);
      ovf_d     = bus.we & full_q;
      udf_d     = bus.re & empty_q;
      ovf_err_d = ovf_err_q | ovf_d;
      udf_err_d = udf_err_q | udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q   <= '0;
      raddr_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign bus.wr_ok     = wr_ok;
  assign bus.rd_ok     = rd_ok;
  assign bus.waddr     = waddr_q;
  assign bus.raddr     = raddr_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.afull     = afull_q;
  assign bus.aempty    = aempty_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.udf_err   = udf_err_q;
endmodule

// File: tb/tb_wl_sfifo_ctrl.sv
// Directed bench: vector table on an H=8 controller, threshold corner cases,
// and an H=6 streaming run through a small RAM model.
module tb_wl_sfifo_ctrl;
  logic clk = 1'b0;
  logic rst, clr;
  always #5 clk = ~clk;

  wl_sfifo_ctrl_if #(.L(3)) bus8 ();
  wl_sfifo_ctrl_if #(.L(3)) bus6 ();

  wl_sfifo_ctrl #(.L(3), .H(8)) dut8 (.clk(clk), .rst(rst), .clr(clr), .bus(bus8.slave));
  wl_sfifo_ctrl #(.L(3), .H(6)) dut6 (.clk(clk), .rst(rst), .clr(clr), .bus(bus6.slave));

  typedef struct {
    logic we, re, clr, rst;
    logic wok, rok;
    int   cnt, wa, ra;
    logic [3:0] flg;  // {full, empty, afull, aempty}
    logic ov, ud, oe, ue;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, re, cl, rs, wok, rok, input int cnt, wa, ra,
                     input logic [3:0] flg, input logic ov, ud, oe, ue);
    vec_t v;
    v = '{we:we, re:re, clr:cl, rst:rs, wok:wok, rok:rok, cnt:cnt, wa:wa, ra:ra,
          flg:flg, ov:ov, ud:ud, oe:oe, ue:ue};
    tv.push_back(v);
  endtask

  task automatic step8(input logic we, re);
    @(negedge clk);
    bus8.we = we; bus8.re = re; rst = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
  endtask

  int wcnt, rcnt, cyc;
  int mem6 [0:5];

  initial begin
    rst = 1'b1; clr = 1'b0;
    bus8.we = 1'b0; bus8.re = 1'b0; bus8.afull_th = 4'd6; bus8.aempty_th = 4'd1;
    bus6.we = 1'b0; bus6.re = 1'b0; bus6.afull_th = 4'd5; bus6.aempty_th = 4'd0;

    //   we re cl rs wok rok cnt wa ra flg      ov ud oe ue
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0101, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 2, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 3, 3, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 4, 4, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 5, 5, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 6, 6, 0, 4'b0010, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 7, 7, 0, 4'b0010, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 8, 0, 0, 4'b1010, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 8, 0, 0, 4'b1010, 1, 0, 1, 0);  // write into full
    add(0, 0, 0, 0, 0, 0, 8, 0, 0, 4'b1010, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 7, 0, 1, 4'b0010, 1, 0, 1, 0);  // full, we&re
    add(0, 0, 0, 0, 0, 0, 7, 0, 1, 4'b0010, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 6, 0, 2, 4'b0010, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 5, 0, 3, 4'b0000, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 4, 0, 4, 4'b0000, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 3, 0, 5, 4'b0000, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 1, 3, 1, 6, 4'b0000, 0, 0, 1, 0);  // count 3, both x4
    add(1, 1, 0, 0, 1, 1, 3, 2, 7, 4'b0000, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 1, 3, 3, 0, 4'b0000, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 1, 3, 4, 1, 4'b0000, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 2, 4, 2, 4'b0000, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 4, 3, 4'b0001, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 4, 4, 4'b0101, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 4, 4, 4'b0101, 0, 1, 1, 1);  // read from empty
    add(1, 1, 0, 0, 1, 0, 1, 5, 4, 4'b0001, 0, 1, 1, 1);  // empty, we&re
    add(0, 0, 0, 0, 0, 0, 1, 5, 4, 4'b0001, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 2, 6, 4, 4'b0000, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 3, 7, 4, 4'b0000, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 4, 0, 4, 4'b0000, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 5, 1, 4, 4'b0000, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0101, 0, 0, 0, 0);  // clr with we
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 2, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 3, 3, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 4, 4, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 5, 5, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0101, 0, 0, 0, 0);  // rst+clr with we
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 0, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      bus8.we = tv[i].we; bus8.re = tv[i].re; clr = tv[i].clr; rst = tv[i].rst;
      #1;
      chk($sformatf("v%0d.wr_ok", i), 32'(bus8.wr_ok), 32'(tv[i].wok));
      chk($sformatf("v%0d.rd_ok", i), 32'(bus8.rd_ok), 32'(tv[i].rok));
      @(posedge clk); #1;
      chk($sformatf("v%0d.count", i), 32'(bus8.count), tv[i].cnt);
      chk($sformatf("v%0d.waddr", i), 32'(bus8.waddr), tv[i].wa);
      chk($sformatf("v%0d.raddr", i), 32'(bus8.raddr), tv[i].ra);
      chk($sformatf("v%0d.flags", i),
          32'({bus8.full, bus8.empty, bus8.afull, bus8.aempty}), 32'(tv[i].flg));
      chk($sformatf("v%0d.overflow", i),  32'(bus8.overflow),  32'(tv[i].ov));
      chk($sformatf("v%0d.underflow", i), 32'(bus8.underflow), 32'(tv[i].ud));
      chk($sformatf("v%0d.ovf_err", i),   32'(bus8.ovf_err),   32'(tv[i].oe));
      chk($sformatf("v%0d.udf_err", i),   32'(bus8.udf_err),   32'(tv[i].ue));
    end

    // Threshold corners: afull_th=0, aempty_th>=H, then afull_th>H.
    @(negedge clk);
    bus8.we = 1'b0; bus8.re = 1'b0; bus8.afull_th = 4'd0; bus8.aempty_th = 4'd8;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("th0.afull_reset", 32'(bus8.afull), 0);
    chk("th0.aempty_reset", 32'(bus8.aempty), 1);
    step8(1'b0, 1'b0);
    chk("th0.afull_first", 32'(bus8.afull), 1);
    for (int i = 0; i < 8; i++) step8(1'b1, 1'b0);
    chk("th0.full", 32'(bus8.full), 1);
    chk("th0.afull_full", 32'(bus8.afull), 1);
    chk("th8.aempty_full", 32'(bus8.aempty), 1);
    bus8.afull_th = 4'd9;
    step8(1'b0, 1'b0);
    chk("th9.afull", 32'(bus8.afull), 0);
    chk("th9.full", 32'(bus8.full), 1);

    // H=6 stream with a RAM model: pointers wrap at 5, order preserved.
    @(negedge clk);
    rst = 1'b1; bus8.we = 1'b0;
    @(posedge clk); #1;
    wcnt = 0; rcnt = 0; cyc = 0;
    while (rcnt < 20 && cyc < 200) begin
      @(negedge clk);
      rst = 1'b0;
      bus6.we = (wcnt < 20) && (cyc % 4 != 3);
      bus6.re = (cyc % 3 != 0);
      #1;
      chk("h6.wr_ok", 32'(bus6.wr_ok), 32'(bus6.we && (wcnt - rcnt != 6)));
      chk("h6.rd_ok", 32'(bus6.rd_ok), 32'(bus6.re && (wcnt - rcnt != 0)));
      chk("h6.waddr_range", 32'(bus6.waddr < 3'd6), 1);
      chk("h6.raddr_range", 32'(bus6.raddr < 3'd6), 1);
      if (bus6.rd_ok) begin
        chk("h6.raddr", 32'(bus6.raddr), rcnt % 6);
        chk("h6.rdata", mem6[bus6.raddr], rcnt + 100);
        rcnt++;
      end
      if (bus6.wr_ok) begin
        chk("h6.waddr", 32'(bus6.waddr), wcnt % 6);
        mem6[bus6.waddr] = wcnt + 100;
        wcnt++;
      end
      @(posedge clk); #1;
      chk("h6.count", 32'(bus6.count), wcnt - rcnt);
      cyc++;
    end
    chk("h6.reads_done", rcnt, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
